// File: rtl/rd_buf_manager_if.sv
// Trigger, word-strobe and AXI-control bundle for the rd_buf_manager ring sequencer.
// The master drives the requests and the slave (the sequencer) drives the status.
interface rd_buf_manager_if;
  logic        trig;
  logic        mem_wrt;
  logic [31:0] ctrl;
  logic        ctrl_wr;

  logic        enable_xfr;
  logic [1:0]  wrt_buf_num;
  logic [1:0]  rd_buf_num;
  logic        trig_out;
  logic [3:0]  buf_full;
  logic        intr;
  logic [31:0] status;

  modport master (
    output trig, mem_wrt, ctrl, ctrl_wr,
    input  enable_xfr, wrt_buf_num, rd_buf_num, trig_out, buf_full, intr, status
  );

  modport slave (
    input  trig, mem_wrt, ctrl, ctrl_wr,
    output enable_xfr, wrt_buf_num, rd_buf_num, trig_out, buf_full, intr, status
  );
endinterface

// File: rtl/rd_buf_manager.sv
// Ring sequencer for four capture buffers: gates transfers on trigger, counts words,
// marks buffers full and hands the oldest full buffer to software for release.
module rd_buf_manager #(
  parameter int unsigned XFR_WORDS   = 2048,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rd_buf_manager_if.slave bus
);

  localparam int unsigned WW = $clog2(XFR_WORDS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  // Both counters are compared before their increment, hence the "- 1".
  localparam logic [WW-1:0] WORDS_LAST = WW'(XFR_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic          trig_prev_q;
  logic          enable_q;
  logic          enable_xfr_q;
  logic          trig_out_q;
  logic [WW-1:0] word_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [3:0]    buf_full_q;
  logic [1:0]    wrt_q;
  logic [1:0]    rd_q;
  logic [7:0]    drop_cnt_q;
  logic          tmo_err_q;
  logic          rel_err_q;

  logic       trig_rise;
  logic       release_req;
  logic       flush_req;
  logic [7:0] drop_cnt_d;
  logic       unused_ctrl_bits;

  assign trig_rise        = bus.trig & ~trig_prev_q;
  assign release_req      = bus.ctrl_wr & bus.ctrl[0];
  assign flush_req        = bus.ctrl_wr & bus.ctrl[1];
  assign drop_cnt_d       = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
  assign unused_ctrl_bits = ^bus.ctrl[31:3];

  // NOTE: every register here uses <= so all branches see the pre-edge values;
  // later assignments in the block (release, then flush) deliberately win.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      trig_prev_q  <= 1'b0;
      enable_q     <= 1'b0;
      enable_xfr_q <= 1'b0;
      trig_out_q   <= 1'b0;
      word_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      buf_full_q   <= '0;
      wrt_q        <= '0;
      rd_q         <= '0;
      drop_cnt_q   <= '0;
      tmo_err_q    <= 1'b0;
      rel_err_q    <= 1'b0;
    end else begin
      trig_prev_q <= bus.trig;
      trig_out_q  <= 1'b0;
      if (bus.ctrl_wr) begin
        enable_q <= bus.ctrl[2];
      end

      unique case (state_q)
        IDLE: begin
          if (trig_rise && enable_q) begin
            if (!buf_full_q[wrt_q]) begin
              state_q      <= XFER;
              word_cnt_q   <= '0;
              tmo_cnt_q    <= '0;
              trig_out_q   <= 1'b1;
              enable_xfr_q <= 1'b1;
            end else begin
              drop_cnt_q <= drop_cnt_d;
            end
          end
        end

        XFER: begin
          if (trig_rise) begin
            drop_cnt_q <= drop_cnt_d;
          end
          if (bus.mem_wrt) begin
            word_cnt_q <= word_cnt_q + WW'(1);
            tmo_cnt_q  <= '0;
            if (word_cnt_q == WORDS_LAST) begin
              state_q      <= DONE;
              enable_xfr_q <= 1'b0;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Stalled transfer: abandon the partial buffer, keep WRT pointing at it.
            state_q      <= IDLE;
            enable_xfr_q <= 1'b0;
            tmo_err_q    <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end

        DONE: begin
          buf_full_q[wrt_q] <= 1'b1;
          wrt_q             <= wrt_q + 2'd1;
          state_q           <= IDLE;
        end

        default: begin
          state_q      <= IDLE;
          enable_xfr_q <= 1'b0;
        end
      endcase

      // A valid release index never equals the buffer finishing in DONE.
      if (release_req) begin
        if (buf_full_q[rd_q]) begin
          buf_full_q[rd_q] <= 1'b0;
          rd_q             <= rd_q + 2'd1;
        end else begin
          rel_err_q <= 1'b1;
        end
      end

      if (flush_req) begin
        state_q      <= IDLE;
        enable_xfr_q <= 1'b0;
        trig_out_q   <= 1'b0;
        buf_full_q   <= '0;
        wrt_q        <= '0;
        rd_q         <= '0;
        drop_cnt_q   <= '0;
        tmo_err_q    <= 1'b0;
        rel_err_q    <= 1'b0;
      end
    end
  end

  assign bus.enable_xfr  = enable_xfr_q;
  assign bus.wrt_buf_num = wrt_q;
  assign bus.rd_buf_num  = rd_q;
  assign bus.trig_out    = trig_out_q;
  assign bus.buf_full    = buf_full_q;
  assign bus.intr        = |buf_full_q;
  assign bus.status      = {8'h00, drop_cnt_q, 3'b000, rel_err_q, tmo_err_q, enable_q,
                            state_q, rd_q, wrt_q, buf_full_q};

endmodule
